// File: rtl/key_entry_ctrl.sv
// Keypad command-entry controller: builds two 3-digit decimal operands and an
// add/subtract opcode from key events, then issues them with a valid/ready handshake.
module key_entry_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keycode,
    input  logic       keystrobe,
    input  logic       cmd_ready,
    output logic [9:0] operand_a,
    output logic [9:0] operand_b,
    output logic       opcode,
    output logic       cmd_valid,
    output logic [1:0] entry_state,
    output logic [1:0] digit_count
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'b00,
        ENTRY_B = 2'b01,
        ISSUE   = 2'b10
    } state_t;

    state_t     state_r, state_s;
    logic       strobe_q_r;
    logic [9:0] operand_a_r, operand_a_s;
    logic [9:0] operand_b_r, operand_b_s;
    logic       opcode_r, opcode_s;
    logic       cmd_valid_r, cmd_valid_s;
    logic [1:0] digit_count_r, digit_count_s;
    logic       key_event_s;

    // x10 + d built from shifts; inputs never exceed 99, so 10 bits cannot overflow
    function automatic logic [9:0] mul10_add(input logic [9:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {6'd0, d};
    endfunction

    assign operand_a   = operand_a_r;
    assign operand_b   = operand_b_r;
    assign opcode      = opcode_r;
    assign cmd_valid   = cmd_valid_r;
    assign entry_state = state_r;
    assign digit_count = digit_count_r;

    // State and datapath registers; strobe_q resets high so a held key is not an event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ENTRY_A;
            strobe_q_r    <= 1'b1;
            operand_a_r   <= 10'd0;
            operand_b_r   <= 10'd0;
            opcode_r      <= 1'b0;
            cmd_valid_r   <= 1'b0;
            digit_count_r <= 2'd0;
        end else begin
            state_r       <= state_s;
            strobe_q_r    <= keystrobe;
            operand_a_r   <= operand_a_s;
            operand_b_r   <= operand_b_s;
            opcode_r      <= opcode_s;
            cmd_valid_r   <= cmd_valid_s;
            digit_count_r <= digit_count_s;
        end
    end

    // Next-state and datapath update on each key event
    always_comb begin
        state_s       = state_r;
        operand_a_s   = operand_a_r;
        operand_b_s   = operand_b_r;
        opcode_s      = opcode_r;
        cmd_valid_s   = cmd_valid_r;
        digit_count_s = digit_count_r;
        key_event_s   = keystrobe & ~strobe_q_r;

        case (state_r)
            ENTRY_A: begin
                if (key_event_s) begin
                    case (keycode)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                            if (digit_count_r != 2'd3) begin
                                operand_a_s   = mul10_add(operand_a_r, keycode);
                                digit_count_s = digit_count_r + 2'd1;
                            end else begin
                                operand_a_s   = operand_a_r;
                            end
                        end
                        4'd10, 4'd11: begin
                            opcode_s      = keycode[0];
                            state_s       = ENTRY_B;
                            digit_count_s = 2'd0;
                            operand_b_s   = 10'd0;
                        end
                        default: state_s = ENTRY_A;
                    endcase
                end else begin
                    state_s = ENTRY_A;
                end
            end
            ENTRY_B: begin
                if (key_event_s) begin
                    case (keycode)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                            if (digit_count_r != 2'd3) begin
                                operand_b_s   = mul10_add(operand_b_r, keycode);
                                digit_count_s = digit_count_r + 2'd1;
                            end else begin
                                operand_b_s   = operand_b_r;
                            end
                        end
                        // operator can be changed only before any B digit
                        4'd10, 4'd11: begin
                            if (digit_count_r == 2'd0) begin
                                opcode_s = keycode[0];
                            end else begin
                                opcode_s = opcode_r;
                            end
                        end
                        4'd12: begin
                            if (digit_count_r != 2'd0) begin
                                state_s     = ISSUE;
                                cmd_valid_s = 1'b1;
                            end else begin
                                state_s     = ENTRY_B;
                            end
                        end
                        default: state_s = ENTRY_B;
                    endcase
                end else begin
                    state_s = ENTRY_B;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_s       = ENTRY_A;
                    cmd_valid_s   = 1'b0;
                    operand_a_s   = 10'd0;
                    operand_b_s   = 10'd0;
                    opcode_s      = 1'b0;
                    digit_count_s = 2'd0;
                end else begin
                    state_s       = ISSUE;
                end
            end
            default: begin
                state_s     = ENTRY_A;
                cmd_valid_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: directed key sequences with a
// command scoreboard checked at every valid/ready handshake.
module tb_key_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keycode;
    logic       keystrobe;
    logic       cmd_ready;
    logic [9:0] operand_a;
    logic [9:0] operand_b;
    logic       opcode;
    logic       cmd_valid;
    logic [1:0] entry_state;
    logic [1:0] digit_count;

    typedef struct {
        int a;
        int b;
        int op;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t mon_c;
    int   checks   = 0;
    int   failures = 0;

    key_entry_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .keycode    (keycode),
        .keystrobe  (keystrobe),
        .cmd_ready  (cmd_ready),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .opcode     (opcode),
        .cmd_valid  (cmd_valid),
        .entry_state(entry_state),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        keycode   = code;
        keystrobe = 1'b1;
        tick(1);
        keystrobe = 1'b0;
        tick(1);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_state"}, int'(entry_state), 0);
        check_val({tag, "_a"}, int'(operand_a), 0);
        check_val({tag, "_b"}, int'(operand_b), 0);
        check_val({tag, "_op"}, int'(opcode), 0);
        check_val({tag, "_valid"}, int'(cmd_valid), 0);
        check_val({tag, "_dc"}, int'(digit_count), 0);
    endtask

    // Handshake monitor: every accepted command must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_cmd", 1, 0);
            end else begin
                mon_c = exp_q.pop_front();
                check_val("sb_a", int'(operand_a), mon_c.a);
                check_val("sb_b", int'(operand_b), mon_c.b);
                check_val("sb_op", int'(opcode), mon_c.op);
                check_val("sb_state", int'(entry_state), 2);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        keycode   = 4'd0;
        keystrobe = 1'b0;
        cmd_ready = 1'b0;
        tick(2);
        check_idle("reset");
        rst = 1'b0;
        tick(2);

        // 123 + 45, held off by cmd_ready for several cycles
        press(4'd1); press(4'd2); press(4'd3);
        check_val("a_123", int'(operand_a), 123);
        check_val("a_dc3", int'(digit_count), 3);
        press(4'd10);
        check_val("add_state", int'(entry_state), 1);
        check_val("add_dc", int'(digit_count), 0);
        press(4'd4); press(4'd5);
        check_val("b_45", int'(operand_b), 45);
        exp_q.push_back('{123, 45, 0});
        press(4'd12);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_val("hold_valid", int'(cmd_valid), 1);
            check_val("hold_a", int'(operand_a), 123);
            check_val("hold_b", int'(operand_b), 45);
            check_val("hold_op", int'(opcode), 0);
        end
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check_idle("after_hs1");

        // 999 (fourth 9 saturates) - 7, ready already high
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        check_val("a_sat", int'(operand_a), 999);
        check_val("a_sat_dc", int'(digit_count), 3);
        press(4'd11); press(4'd7);
        cmd_ready = 1'b1;
        exp_q.push_back('{999, 7, 1});
        keycode   = 4'd12;
        keystrobe = 1'b1;
        tick(1);
        check_val("one_cyc_valid", int'(cmd_valid), 1);
        keystrobe = 1'b0;
        tick(1);
        cmd_ready = 1'b0;
        check_idle("after_hs2");

        // long hold of one key gives one digit
        keycode   = 4'd5;
        keystrobe = 1'b1;
        tick(20);
        keystrobe = 1'b0;
        tick(1);
        check_val("hold_a5", int'(operand_a), 5);
        check_val("hold_dc1", int'(digit_count), 1);

        // enter in A, multi-press/unused codes, operator swap, enter with no B digits
        press(4'd12);
        check_val("enterA_state", int'(entry_state), 0);
        press(4'd15); press(4'd13);
        check_val("ign_a", int'(operand_a), 5);
        check_val("ign_dc", int'(digit_count), 1);
        press(4'd10);
        press(4'd11);
        press(4'd12);
        check_val("swap_state", int'(entry_state), 1);
        check_val("swap_op", int'(opcode), 1);
        check_val("swap_valid", int'(cmd_valid), 0);
        press(4'd3); press(4'd10);
        check_val("late_op", int'(opcode), 1);

        // reset mid-entry clears immediately; held key across release is no event
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        press(4'd4); press(4'd10); press(4'd6);
        check_val("pre_rst_b", int'(operand_b), 6);
        keycode   = 4'd7;
        keystrobe = 1'b1;
        rst       = 1'b1;
        #1;
        check_idle("async_rst");
        tick(2);
        rst = 1'b0;
        tick(3);
        check_val("held_rst_a", int'(operand_a), 0);
        check_val("held_rst_dc", int'(digit_count), 0);
        keystrobe = 1'b0;
        tick(1);

        // key during ISSUE is dropped; next command starts from a=0
        press(4'd1); press(4'd10); press(4'd2);
        exp_q.push_back('{1, 2, 0});
        press(4'd12);
        press(4'd3);
        check_val("issue_a", int'(operand_a), 1);
        check_val("issue_dc", int'(digit_count), 1);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check_idle("after_hs3");
        press(4'd10); press(4'd8);
        exp_q.push_back('{0, 8, 0});
        press(4'd12);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        tick(1);

        check_val("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 keycode  input  4  key code from the keypad encoder: 0-9 digit, 10 add, 11 subtract, 12 enter, 15 multi-press, 13/14 unused.
REQ-005 keystrobe  input  1  high while a valid key is held; keycode is meaningful only while high.
REQ-006 cmd_ready  input  1  downstream accepts the command when high with cmd_valid.
REQ-007 operand_a  output  10  first operand, unsigned decimal 0-999.
REQ-008 operand_b  output  10  second operand, unsigned decimal 0-999.
REQ-009 opcode  output  1  0 = add, 1 = subtract.
REQ-010 cmd_valid  output  1  command (operand_a, operand_b, opcode) is available.
REQ-011 entry_state  output  2  current FSM state encoding: 00 ENTRY_A, 01 ENTRY_B, 10 ISSUE.
REQ-012 digit_count  output  2  digits entered into the operand currently being built (0-3).

Function
REQ-013 Key events SHALL be detected on the rising edge of keystrobe: event = keystrobe & ~strobe_q, where strobe_q is keystrobe registered on every clk edge.
REQ-014 A held key SHALL produce exactly one event, whatever its hold time.
REQ-015 keycode SHALL be sampled in the same cycle as the event, and all resulting register updates SHALL be visible after that clock edge (1-cycle latency).
REQ-016 Codes 13, 14 and 15 SHALL be ignored: no state, operand or count change.
REQ-017 ENTRY_A, digit d with digit_count<3: operand_a <= operand_a*10 + d; digit_count increments.
REQ-018 ENTRY_A, digit with digit_count==3: ignored; operand_a saturates at 3 digits.
REQ-019 ENTRY_A, add/subtract: opcode <= 0/1; state -> ENTRY_B; digit_count <= 0; operand_b <= 0.
REQ-020 ENTRY_A, enter: ignored.
REQ-021 ENTRY_B, digits follow REQ-017 and REQ-018, applied to operand_b.
REQ-022 ENTRY_B, add/subtract with digit_count==0: replaces opcode; state unchanged.
REQ-023 ENTRY_B, add/subtract with digit_count>0: ignored.
REQ-024 ENTRY_B, enter with digit_count==0: ignored.
REQ-025 ENTRY_B, enter with digit_count>0: state -> ISSUE; cmd_valid <= 1.
REQ-026 In ISSUE, cmd_valid, operand_a, operand_b and opcode SHALL remain stable until the cycle in which cmd_ready=1.
REQ-027 In ISSUE, all key events SHALL be ignored.
REQ-028 On the clock edge where cmd_valid & cmd_ready: cmd_valid <= 0; operand_a <= 0; operand_b <= 0; opcode <= 0; digit_count <= 0; state -> ENTRY_A.
REQ-029 The x10 accumulate SHALL be computed at 10-bit width; the maximum value is 999, so no overflow occurs.
REQ-030 cmd_valid SHALL be asserted only in ISSUE.
REQ-031 entry_state SHALL never take the value 11; an illegal state SHALL recover to ENTRY_A on the next edge.

Reset
REQ-032 rst=1 SHALL immediately force: state ENTRY_A, operand_a=0, operand_b=0, opcode=0, cmd_valid=0, digit_count=0.
REQ-033 rst=1 SHALL also immediately force strobe_q=1, so a key held through reset release produces no event.
REQ-034 Reset asserted mid-entry or during ISSUE SHALL discard the pending command without a handshake.

Verification
REQ-035 Press 1,2,3, add, 4,5, enter -> cmd_valid=1, operand_a=123, operand_b=45, opcode=0; hold cmd_ready=0 for 5 cycles -> outputs stable.
REQ-036 Press 9,9,9,9, subtract, 7, enter, with cmd_ready=1 -> operand_a=999, opcode=1, operand_b=7; cmd_valid high 1 cycle; then state 00 with all outputs 0.
REQ-037 Hold keystrobe=1 with keycode=5 for 20 cycles in ENTRY_A -> operand_a=5, digit_count=1.
REQ-038 Send enter in ENTRY_A; keycode 15; then add, subtract, enter with no B digits -> state 01, opcode=1, cmd_valid=0.
REQ-039 Assert rst after entering 4, add, 6 -> all outputs 0 immediately; keystrobe held across release produces no event.
REQ-040 During ISSUE, press 3 then release cmd_ready -> next command's operand_a=0; the press is not captured.
